// File: rtl/riscv_v_pkg.sv
// Shared vector types for the element-sequencing decoder: vtype layout, SEW/LMUL
// encodings, per-beat byte qualifiers and width helpers.
package riscv_v_pkg;

    localparam int RISCV_V_MAX_LMUL = 8;
    // Beat qualifier vectors are sized for VLEN up to 128 bits.
    localparam int RISCV_V_VLENB = 16;

    typedef enum logic [2:0] {
        OSIZE_8   = 3'd0,
        OSIZE_16  = 3'd1,
        OSIZE_32  = 3'd2,
        OSIZE_64  = 3'd3,
        OSIZE_128 = 3'd4
    } riscv_v_osize_e;

    typedef enum logic [2:0] {
        VLMUL_1    = 3'd0,
        VLMUL_2    = 3'd1,
        VLMUL_4    = 3'd2,
        VLMUL_8    = 3'd3,
        VLMUL_RSVD = 3'd4,
        VLMUL_F8   = 3'd5,
        VLMUL_F4   = 3'd6,
        VLMUL_F2   = 3'd7
    } riscv_v_vlmul_e;

    typedef struct packed {
        logic           vill;
        logic           vma;
        logic           vta;
        logic [2:0]     vsew;
        riscv_v_vlmul_e vlmul;
    } riscv_v_vtype_t;

    typedef struct packed {
        logic [RISCV_V_VLENB-1:0] active;
        logic [RISCV_V_VLENB-1:0] merge;
        logic [RISCV_V_VLENB-1:0] tail;
        logic [RISCV_V_VLENB-1:0] prestart;
    } riscv_v_beat_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } riscv_v_seq_state_e;

    function automatic int riscv_v_vlw(input int max_lmul, input int data_width);
        return $clog2(max_lmul * data_width / 8) + 1;
    endfunction

    // Fractional LMUL still occupies one whole register.
    function automatic int riscv_v_lmul_beats(input riscv_v_vlmul_e vlmul, input int max_lmul);
        int n;
        case (vlmul)
            VLMUL_1: n = 1;
            VLMUL_2: n = 2;
            VLMUL_4: n = 4;
            VLMUL_8: n = 8;
            default: n = 1;
        endcase
        if (n > max_lmul) begin
            n = max_lmul;
        end
        return n;
    endfunction

endpackage

// File: rtl/riscv_v_elem_mask_gen.sv
// Combinational per-byte qualifier generator for one register of a vector group.
module riscv_v_elem_mask_gen
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_LMUL   = 8,
    parameter int VLW        = riscv_v_vlw(MAX_LMUL, DATA_WIDTH),
    parameter int RW         = $clog2(MAX_LMUL) + 1
) (
    input  logic [RW-1:0]         beat_idx,
    input  logic [2:0]            vsew,
    input  logic [VLW-1:0]        vl,
    input  logic [VLW-1:0]        vstart,
    input  logic                  vm,
    input  logic [DATA_WIDTH-1:0] mask,
    output riscv_v_beat_t         beat
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int MIW = $clog2(DATA_WIDTH);

    logic [31:0] elem;
    logic        pre;
    logic        tl;
    logic        mbit;

    // Map every byte lane to its element index and classify it.
    always_comb begin
        beat = '0;
        elem = 32'd0;
        pre  = 1'b0;
        tl   = 1'b0;
        mbit = 1'b0;
        for (int b = 0; b < NB; b++) begin
            elem = 32'(beat_idx) * (32'(NB) >> vsew) + (32'(b) >> vsew);
            pre  = elem < 32'(vstart);
            tl   = elem >= 32'(vl);
            if (elem < 32'(DATA_WIDTH)) begin
                mbit = mask[elem[MIW-1:0]];
            end else begin
                mbit = 1'b0;
            end
            beat.prestart[b] = pre;
            beat.tail[b]     = tl;
            beat.active[b]   = !pre && !tl && (vm || mbit);
            beat.merge[b]    = ((32'(b) + 32'd1) & ((32'd1 << vsew) - 32'd1)) != 32'd0;
        end
    end

endmodule

// File: rtl/riscv_v_decode_element_seq.sv
// Vector element sequencer: accepts one op descriptor and walks its LMUL register
// group one register per beat, emitting per-byte qualifiers to the ALU lanes.
module riscv_v_decode_element_seq
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_LMUL   = 8,
    parameter int NUM_OSIZES = 5
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  riscv_v_vtype_t                            in_vtype,
    input  logic [riscv_v_vlw(MAX_LMUL,DATA_WIDTH)-1:0] in_vl,
    input  logic [riscv_v_vlw(MAX_LMUL,DATA_WIDTH)-1:0] in_vstart,
    input  logic                                      in_vm,
    input  logic [DATA_WIDTH-1:0]                     in_mask,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$clog2(MAX_LMUL):0]                 out_reg_ofs,
    output logic [DATA_WIDTH/8-1:0]                   out_active,
    output logic [DATA_WIDTH/8-1:0]                   out_merge,
    output logic [DATA_WIDTH/8-1:0]                   out_tail,
    output logic [DATA_WIDTH/8-1:0]                   out_prestart,
    output riscv_v_osize_e                            out_osize,
    output logic                                      out_first,
    output logic                                      out_last,
    output logic                                      out_err,
    output logic                                      done
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int VLW = riscv_v_vlw(MAX_LMUL, DATA_WIDTH);
    localparam int RW  = $clog2(MAX_LMUL) + 1;

    riscv_v_seq_state_e    state;
    logic [2:0]            vsew_r;
    logic [VLW-1:0]        vl_r;
    logic [VLW-1:0]        vstart_r;
    logic                  vm_r;
    logic [DATA_WIDTH-1:0] mask_r;
    logic [RW-1:0]         nbeats_r;

    logic                  acc;
    logic                  hs;
    logic                  illegal_in;
    logic                  zero_in;
    logic [RW-1:0]         in_beats;
    logic [31:0]           cap;
    logic [VLW-1:0]        in_vl_sat;
    logic [RW-1:0]         nxt_ofs;

    logic [RW-1:0]         g_beat;
    logic [2:0]            g_vsew;
    logic [VLW-1:0]        g_vl;
    logic [VLW-1:0]        g_vstart;
    logic                  g_vm;
    logic [DATA_WIDTH-1:0] g_mask;
    riscv_v_beat_t         g_out;

    assign in_ready = (state == ST_IDLE) || (out_valid && out_ready && out_last);
    assign acc      = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign nxt_ofs  = out_reg_ofs + RW'(1);

    // Incoming descriptor decode; vl saturates to the group capacity.
    always_comb begin
        in_beats   = RW'(riscv_v_lmul_beats(in_vtype.vlmul, MAX_LMUL));
        illegal_in = in_vtype.vill || (int'(in_vtype.vsew) >= NUM_OSIZES)
                     || (in_vtype.vlmul == VLMUL_RSVD);
        cap        = 32'(in_beats) * (32'(NB) >> in_vtype.vsew);
        if (32'(in_vl) > cap) begin
            in_vl_sat = VLW'(cap);
        end else begin
            in_vl_sat = in_vl;
        end
        zero_in = !illegal_in && ((in_vl_sat == '0) || (in_vstart >= in_vl_sat));
    end

    // The qualifier generator sees the new op on accept, otherwise the next beat.
    always_comb begin
        if (acc) begin
            g_beat   = '0;
            g_vsew   = in_vtype.vsew;
            g_vl     = in_vl_sat;
            g_vstart = in_vstart;
            g_vm     = in_vm;
            g_mask   = in_mask;
        end else begin
            g_beat   = nxt_ofs;
            g_vsew   = vsew_r;
            g_vl     = vl_r;
            g_vstart = vstart_r;
            g_vm     = vm_r;
            g_mask   = mask_r;
        end
    end

    riscv_v_elem_mask_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LMUL   (MAX_LMUL),
        .VLW        (VLW),
        .RW         (RW)
    ) u_mask_gen (
        .beat_idx (g_beat),
        .vsew     (g_vsew),
        .vl       (g_vl),
        .vstart   (g_vstart),
        .vm       (g_vm),
        .mask     (g_mask),
        .beat     (g_out)
    );

    // Sequencer FSM with registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_reg_ofs  <= '0;
            out_active   <= '0;
            out_merge    <= '0;
            out_tail     <= '0;
            out_prestart <= '0;
            out_osize    <= OSIZE_8;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_err      <= 1'b0;
            done         <= 1'b0;
            vsew_r       <= 3'd0;
            vl_r         <= '0;
            vstart_r     <= '0;
            vm_r         <= 1'b0;
            mask_r       <= '0;
            nbeats_r     <= '0;
        end else begin
            done <= 1'b0;
            if (acc) begin
                vsew_r   <= in_vtype.vsew;
                vl_r     <= in_vl_sat;
                vstart_r <= in_vstart;
                vm_r     <= in_vm;
                mask_r   <= in_mask;
                nbeats_r <= in_beats;
                // A same-cycle accept only happens on the previous op's last handshake.
                done     <= hs || zero_in;
                out_reg_ofs <= '0;
                if (zero_in) begin
                    state        <= ST_IDLE;
                    out_valid    <= 1'b0;
                    out_active   <= '0;
                    out_merge    <= '0;
                    out_tail     <= '0;
                    out_prestart <= '0;
                    out_first    <= 1'b0;
                    out_last     <= 1'b0;
                    out_err      <= 1'b0;
                end else begin
                    state     <= ST_ISSUE;
                    out_valid <= 1'b1;
                    out_first <= 1'b1;
                    out_last  <= illegal_in || (in_beats == RW'(1));
                    out_err   <= illegal_in;
                    if (illegal_in) begin
                        out_osize    <= OSIZE_8;
                        out_active   <= '0;
                        out_merge    <= '0;
                        out_tail     <= '0;
                        out_prestart <= '0;
                    end else begin
                        out_osize    <= riscv_v_osize_e'(in_vtype.vsew);
                        out_active   <= g_out.active[NB-1:0];
                        out_merge    <= g_out.merge[NB-1:0];
                        out_tail     <= g_out.tail[NB-1:0];
                        out_prestart <= g_out.prestart[NB-1:0];
                    end
                end
            end else if (hs) begin
                if (out_last) begin
                    state        <= ST_IDLE;
                    out_valid    <= 1'b0;
                    done         <= 1'b1;
                    out_reg_ofs  <= '0;
                    out_active   <= '0;
                    out_merge    <= '0;
                    out_tail     <= '0;
                    out_prestart <= '0;
                    out_first    <= 1'b0;
                    out_last     <= 1'b0;
                    out_err      <= 1'b0;
                end else begin
                    out_reg_ofs  <= nxt_ofs;
                    out_first    <= 1'b0;
                    out_last     <= (nxt_ofs == nbeats_r - RW'(1));
                    out_active   <= g_out.active[NB-1:0];
                    out_merge    <= g_out.merge[NB-1:0];
                    out_tail     <= g_out.tail[NB-1:0];
                    out_prestart <= g_out.prestart[NB-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_decode_element_seq.sv
// Directed self-checking bench for riscv_v_decode_element_seq at VLEN=128.
module tb_riscv_v_decode_element_seq;
    import riscv_v_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    riscv_v_vtype_t in_vtype;
    logic [7:0]     in_vl;
    logic [7:0]     in_vstart;
    logic           in_vm;
    logic [127:0]   in_mask;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_reg_ofs;
    logic [15:0]    out_active;
    logic [15:0]    out_merge;
    logic [15:0]    out_tail;
    logic [15:0]    out_prestart;
    riscv_v_osize_e out_osize;
    logic           out_first;
    logic           out_last;
    logic           out_err;
    logic           done;

    int checks = 0;
    int errors = 0;
    logic [56:0] exp_v;

    riscv_v_decode_element_seq #(
        .DATA_WIDTH (128),
        .MAX_LMUL   (8),
        .NUM_OSIZES (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vtype     (in_vtype),
        .in_vl        (in_vl),
        .in_vstart    (in_vstart),
        .in_vm        (in_vm),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_reg_ofs  (out_reg_ofs),
        .out_active   (out_active),
        .out_merge    (out_merge),
        .out_tail     (out_tail),
        .out_prestart (out_prestart),
        .out_osize    (out_osize),
        .out_first    (out_first),
        .out_last     (out_last),
        .out_err      (out_err),
        .done         (done)
    );

    always #5 clk = ~clk;

    // {valid, ofs, active, tail, prestart, first, last, err, done}
    function automatic logic [56:0] obs();
        return {out_valid, out_reg_ofs, out_active, out_tail, out_prestart,
                out_first, out_last, out_err, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] sew, input logic [2:0] lmul, input logic vill,
                         input logic [7:0] vl, input logic [7:0] vstart, input logic vm,
                         input logic [127:0] mask);
        in_vtype.vill  = vill;
        in_vtype.vma   = 1'b0;
        in_vtype.vta   = 1'b0;
        in_vtype.vsew  = sew;
        in_vtype.vlmul = riscv_v_vlmul_e'(lmul);
        in_vl     = vl;
        in_vstart = vstart;
        in_vm     = vm;
        in_mask   = mask;
        in_valid  = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) begin
            step();
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
            errors++;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || out_err !== 1'b0) begin
            $display("FAIL reset_ctrl: valid=%b done=%b err=%b required 0 0 0", out_valid, done, out_err);
            errors++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
            errors++;
        end
        checks++;
        if ({out_reg_ofs, out_active, out_merge, out_tail, out_prestart} !== 68'h0) begin
            $display("FAIL reset_masks: got %h required 0", {out_reg_ofs, out_active, out_merge, out_tail, out_prestart});
            errors++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_beat();
        issue(3'd2, 3'd0, 1'b0, 8'd3, 8'd0, 1'b1, 128'h0);
        exp_v = {1'b1, 4'd0, 16'h0FFF, 16'hF000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL sew32_beat: got %h required %h", obs(), exp_v);
            errors++;
        end
        checks++;
        if (out_merge !== 16'h7777 || out_osize !== OSIZE_32) begin
            $display("FAIL sew32_merge: merge=%h osize=%0d required 7777 2", out_merge, out_osize);
            errors++;
        end
        step();
        exp_v = {1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL sew32_done: got %h required %h", obs(), exp_v);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL sew32_done_pulse: done=%b required 0", done);
            errors++;
        end
    endtask

    task automatic test_prestart_tail();
        issue(3'd0, 3'd1, 1'b0, 8'd20, 8'd2, 1'b1, 128'h0);
        exp_v = {1'b1, 4'd0, 16'hFFFC, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul2_beat0: got %h required %h", obs(), exp_v);
            errors++;
        end
        step();
        exp_v = {1'b1, 4'd1, 16'h000F, 16'hFFF0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v || out_merge !== 16'h0000) begin
            $display("FAIL lmul2_beat1: got %h merge %h required %h merge 0000", obs(), out_merge, exp_v);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL lmul2_done: done=%b valid=%b required 1 0", done, out_valid);
            errors++;
        end
    endtask

    task automatic test_masked();
        issue(3'd1, 3'd0, 1'b0, 8'd8, 8'd0, 1'b0, 128'h5);
        exp_v = {1'b1, 4'd0, 16'h0033, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v || out_merge !== 16'h5555) begin
            $display("FAIL sew16_masked: got %h merge %h required %h merge 5555", obs(), out_merge, exp_v);
            errors++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 3'd2, 1'b0, 8'd50, 8'd20, 1'b1, 128'h0);
        exp_v = {1'b1, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul4_beat0: got %h required %h", obs(), exp_v);
            errors++;
        end
        step();
        exp_v = {1'b1, 4'd1, 16'hFFF0, 16'h0000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs() !== exp_v) begin
                $display("FAIL lmul4_hold%0d: got %h required %h", c, obs(), exp_v);
                errors++;
            end
            step();
        end
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul4_hold_end: got %h required %h", obs(), exp_v);
            errors++;
        end
        out_ready = 1'b1;
        step();
        exp_v = {1'b1, 4'd2, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul4_beat2: got %h required %h", obs(), exp_v);
            errors++;
        end
        step();
        exp_v = {1'b1, 4'd3, 16'h0003, 16'hFFFC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul4_beat3: got %h required %h", obs(), exp_v);
            errors++;
        end
        issue(3'd2, 3'd0, 1'b0, 8'd3, 8'd0, 1'b1, 128'h0);
        exp_v = {1'b1, 4'd0, 16'h0FFF, 16'hF000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL b2b_first: got %h required %h", obs(), exp_v);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL b2b_done: done=%b valid=%b required 1 0", done, out_valid);
            errors++;
        end
    endtask

    task automatic test_illegal_zero();
        logic [2:0] sews [3]  = '{3'd5, 3'd0, 3'd0};
        logic [2:0] lmuls [3] = '{3'd0, 3'd4, 3'd0};
        logic       vills [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            issue(sews[t], lmuls[t], vills[t], 8'd4, 8'd0, 1'b1, 128'h0);
            exp_v = {1'b1, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs() !== exp_v || out_merge !== 16'h0) begin
                $display("FAIL illegal%0d: got %h merge %h required %h merge 0000", t, obs(), out_merge, exp_v);
                errors++;
            end
            step();
            checks++;
            if (done !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL illegal%0d_done: done=%b valid=%b required 1 0", t, done, out_valid);
                errors++;
            end
        end
        for (int t = 0; t < 2; t++) begin
            issue(3'd0, 3'd0, 1'b0, (t == 0) ? 8'd0 : 8'd4, (t == 0) ? 8'd0 : 8'd4, 1'b1, 128'h0);
            exp_v = {1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs() !== exp_v) begin
                $display("FAIL zero%0d: got %h required %h", t, obs(), exp_v);
                errors++;
            end
            step();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                $display("FAIL zero%0d_after: done=%b valid=%b required 0 0", t, done, out_valid);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        issue(3'd0, 3'd3, 1'b0, 8'd128, 8'd0, 1'b1, 128'h0);
        step();
        step();
        exp_v = {1'b1, 4'd2, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== exp_v) begin
            $display("FAIL lmul8_beat2: got %h required %h", obs(), exp_v);
            errors++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_ofs !== 4'd0) begin
            $display("FAIL rst_abort: valid=%b ready=%b ofs=%0d required 0 1 0", out_valid, in_ready, out_reg_ofs);
            errors++;
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                $display("FAIL rst_no_done%0d: done=%b valid=%b required 0 0", c, done, out_valid);
                errors++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vtype  = '0;
        in_vl     = 8'd0;
        in_vstart = 8'd0;
        in_vm     = 1'b1;
        in_mask   = 128'h0;
        out_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_prestart_tail();
        test_masked();
        test_back_to_back();
        test_illegal_zero();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
